// File: rtl/spi_regbank.sv
//------------------------------------------------------------------------------
// spi_regbank
//
// SPI (mode 0, MSB first) slave giving a host access to a small bank of
// registers and a read-only memory window.
//
// A transaction is: ncs fall, an 8-bit control byte {wr, mem, idx[5:0]}, then
// data words until ncs rises.  While the control byte is clocked in, miso
// returns a signature byte (8'hA5, or 8'h25 while the sticky error is set).
//   mem=0 : register access.  A read returns reg_d[i] for read-only registers
//           and reg_q[i] otherwise.  A write commits on the last bit of the
//           word.  Without burst mode only one word is transferred and the
//           remaining bits are drained.
//   mem=1 : memory read stream.  mem_addr restarts at 0 and advances by one
//           after each word is loaded.
//
// Optional feature (compile-time macro SPI_REGBANK_BURST_EN):
//   defined   : the register index auto-increments after every REG word.
//   undefined : one REG word per transaction, then DRAIN.
//
// Ports
//   clk        system clock (at least 8x sck)
//   rst_n      synchronous active-low reset
//   sck/mosi/ncs  raw asynchronous SPI inputs
//   miso       SPI data out (registered)
//   reg_d      NREG*DW status inputs, slice i belongs to register i
//   reg_q      NREG*DW writable register contents
//   wr_strobe  one-clk pulse when a register write commits
//   wr_idx     index of the committed register
//   err        sticky bad-index flag
//   mem_data   memory read data (1 clk latency after mem_addr)
//   mem_addr   memory read address
//------------------------------------------------------------------------------
module spi_regbank #(
   parameter int              NREG    = 4,
   parameter int              DW      = 32,
   parameter logic [NREG-1:0] RO_MASK = 4'b0010,
   parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
   parameter int              MEM_AW  = 12,
   parameter int              MEM_DW  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sck,
   input  logic                 mosi,
   input  logic                 ncs,
   output logic                 miso,
   input  logic [NREG*DW-1:0]   reg_d,
   output logic [NREG*DW-1:0]   reg_q,
   output logic                 wr_strobe,
   output logic [5:0]           wr_idx,
   output logic                 err,
   input  logic [MEM_DW-1:0]    mem_data,
   output logic [MEM_AW-1:0]    mem_addr
);

   // Transmit shift register is wide enough for any word; words are loaded
   // MSB-aligned so miso is always its top bit.
   localparam int SW0 = (DW > MEM_DW) ? DW : MEM_DW;
   localparam int SW  = (SW0 > 8) ? SW0 : 8;

`ifdef SPI_REGBANK_BURST_EN
   localparam logic BURST = 1'b1;
`else
   localparam logic BURST = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CTRL  = 3'd1,
      REG   = 3'd2,
      MEM   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;

   logic              sck_meta_r, sck_sync_r, sck_prev_r;
   logic              mosi_meta_r, mosi_sync_r;
   logic              ncs_meta_r, ncs_sync_r, ncs_prev_r;
   logic              sck_rise_s, sck_fall_s, ncs_fall_s, ncs_rise_s;

   logic [DW-1:0]     rx_sh_r;
   logic [SW-1:0]     tx_sh_r;
   logic [7:0]        bit_cnt_r;
   logic              load_pend_r;
   logic              wr_r;
   logic [6:0]        cur_idx_r;
   logic [6:0]        next_idx_s;
   logic              commit_r;
   logic              wr_strobe_r;
   logic [5:0]        wr_idx_r;
   logic              err_r;
   logic              mem_inc_r;
   logic [MEM_AW-1:0] mem_addr_r;
   logic [DW-1:0]     reg_arr_r [NREG];

   logic [7:0]        ctrl_s;
   logic              ctrl_done_s, reg_done_s, mem_done_s;
   logic              valid_idx_s, next_valid_s, ro_sel_s;
   logic [DW-1:0]     rd_word_s;
   logic [SW-1:0]     ctrl_word_s, reg_word_s, mem_word_s;

   // Two-flop synchronisers plus one history flop for edge detection.
   // The ncs chain resets low so that a select already held low when reset
   // is released is not mistaken for a fresh ncs fall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_meta_r  <= 1'b0;
         sck_sync_r  <= 1'b0;
         sck_prev_r  <= 1'b0;
         mosi_meta_r <= 1'b0;
         mosi_sync_r <= 1'b0;
         ncs_meta_r  <= 1'b0;
         ncs_sync_r  <= 1'b0;
         ncs_prev_r  <= 1'b0;
      end else begin
         sck_meta_r  <= sck;
         sck_sync_r  <= sck_meta_r;
         sck_prev_r  <= sck_sync_r;
         mosi_meta_r <= mosi;
         mosi_sync_r <= mosi_meta_r;
         ncs_meta_r  <= ncs;
         ncs_sync_r  <= ncs_meta_r;
         ncs_prev_r  <= ncs_sync_r;
      end
   end

   assign sck_rise_s = sck_sync_r & ~sck_prev_r;
   assign sck_fall_s = ~sck_sync_r & sck_prev_r;
   assign ncs_fall_s = ~ncs_sync_r & ncs_prev_r;
   assign ncs_rise_s = ncs_sync_r & ~ncs_prev_r;

   // Control byte as it stands on the rising edge of its 8th bit.
   assign ctrl_s      = {rx_sh_r[6:0], mosi_sync_r};
   assign ctrl_done_s = (state_r == CTRL) && sck_rise_s && (bit_cnt_r == 8'd7);
   assign reg_done_s  = (state_r == REG) && sck_rise_s && (bit_cnt_r == 8'(DW - 1));
   assign mem_done_s  = (state_r == MEM) && sck_rise_s && (bit_cnt_r == 8'(MEM_DW - 1));

   // Index saturates at 127 so a long burst can never wrap back onto a valid register.
   assign next_idx_s   = (cur_idx_r == 7'h7F) ? cur_idx_r : (cur_idx_r + 7'd1);
   assign valid_idx_s  = (cur_idx_r < 7'(NREG));
   assign next_valid_s = (next_idx_s < 7'(NREG));

   // Read-back mux: status input for read-only registers, stored value otherwise.
   always_comb begin
      rd_word_s = {DW{1'b0}};
      ro_sel_s  = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (cur_idx_r == 7'(i)) begin
            ro_sel_s  = RO_MASK[i];
            rd_word_s = RO_MASK[i] ? reg_d[i*DW +: DW] : reg_arr_r[i];
         end else begin
            ro_sel_s  = ro_sel_s;
            rd_word_s = rd_word_s;
         end
      end
   end

   // MSB-aligned load images for the transmit shift register.
   always_comb begin
      ctrl_word_s = {SW{1'b0}};
      reg_word_s  = {SW{1'b0}};
      mem_word_s  = {SW{1'b0}};
      if (err_r) begin
         ctrl_word_s[SW-1 -: 8] = 8'h25;
      end else begin
         ctrl_word_s[SW-1 -: 8] = 8'hA5;
      end
      if (valid_idx_s) begin
         reg_word_s[SW-1 -: DW] = rd_word_s;
      end else begin
         reg_word_s = {SW{1'b0}};
      end
      mem_word_s[SW-1 -: MEM_DW] = mem_data;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; ncs rise always wins.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (ncs_fall_s) begin
               state_nxt_s = CTRL;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CTRL: begin
            if (ncs_rise_s) begin
               state_nxt_s = IDLE;
            end else if (ctrl_done_s) begin
               state_nxt_s = ctrl_s[6] ? MEM : REG;
            end else begin
               state_nxt_s = CTRL;
            end
         end
         REG: begin
            if (ncs_rise_s) begin
               state_nxt_s = IDLE;
            end else if (reg_done_s) begin
               state_nxt_s = BURST ? REG : DRAIN;
            end else begin
               state_nxt_s = REG;
            end
         end
         MEM, DRAIN: begin
            if (ncs_rise_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Shift datapath, word sequencing, write commit request and sticky error.
   // Bits are taken on sck rise; miso moves on sck fall.  A word boundary
   // seen on a rise arms load_pend_r so the next fall loads a fresh word
   // instead of shifting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_sh_r     <= {DW{1'b0}};
         tx_sh_r     <= {SW{1'b0}};
         bit_cnt_r   <= 8'd0;
         load_pend_r <= 1'b0;
         wr_r        <= 1'b0;
         cur_idx_r   <= 7'd0;
         commit_r    <= 1'b0;
         wr_idx_r    <= 6'd0;
         err_r       <= 1'b0;
         mem_inc_r   <= 1'b0;
      end else begin
         commit_r  <= 1'b0;
         mem_inc_r <= 1'b0;
         case (state_r)
            IDLE: begin
               bit_cnt_r   <= 8'd0;
               load_pend_r <= 1'b0;
               // First control-byte bit goes out immediately on select.
               tx_sh_r     <= ncs_fall_s ? ctrl_word_s : {SW{1'b0}};
            end
            CTRL, REG, MEM, DRAIN: begin
               if (ncs_rise_s) begin
                  tx_sh_r     <= {SW{1'b0}};
                  bit_cnt_r   <= 8'd0;
                  load_pend_r <= 1'b0;
               end else if (sck_rise_s) begin
                  if (state_r != DRAIN) begin
                     rx_sh_r   <= {rx_sh_r[DW-2:0], mosi_sync_r};
                     bit_cnt_r <= bit_cnt_r + 8'd1;
                  end
                  if (ctrl_done_s) begin
                     bit_cnt_r   <= 8'd0;
                     load_pend_r <= 1'b1;
                     wr_r        <= ctrl_s[7];
                     cur_idx_r   <= {1'b0, ctrl_s[5:0]};
                     if (!ctrl_s[6] && ({1'b0, ctrl_s[5:0]} >= 7'(NREG))) begin
                        err_r <= 1'b1;
                     end
                  end else if (reg_done_s) begin
                     bit_cnt_r <= 8'd0;
                     if (wr_r && valid_idx_s && !ro_sel_s) begin
                        commit_r <= 1'b1;
                        wr_idx_r <= cur_idx_r[5:0];
                     end
                     if (wr_r && (cur_idx_r == 7'd63)) begin
                        err_r <= 1'b0;
                     end
                     if (BURST) begin
                        cur_idx_r   <= next_idx_s;
                        load_pend_r <= 1'b1;
                        // Each burst word is checked on its own index.
                        if (!next_valid_s) begin
                           err_r <= 1'b1;
                        end
                     end else begin
                        tx_sh_r <= {SW{1'b0}};
                     end
                  end else if (mem_done_s) begin
                     bit_cnt_r   <= 8'd0;
                     load_pend_r <= 1'b1;
                  end
               end else if (sck_fall_s) begin
                  if (load_pend_r) begin
                     load_pend_r <= 1'b0;
                     if (state_r == MEM) begin
                        tx_sh_r   <= mem_word_s;
                        mem_inc_r <= 1'b1;
                     end else begin
                        tx_sh_r <= reg_word_s;
                     end
                  end else begin
                     tx_sh_r <= {tx_sh_r[SW-2:0], 1'b0};
                  end
               end
            end
            default: begin
               tx_sh_r     <= {SW{1'b0}};
               bit_cnt_r   <= 8'd0;
               load_pend_r <= 1'b0;
            end
         endcase
      end
   end

   // Register storage: commit one clk after the last data bit, strobe alongside.
   // Read-only slices are never written and therefore stay at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_strobe_r <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            reg_arr_r[i] <= RO_MASK[i] ? {DW{1'b0}} : RST_VAL;
         end
      end else begin
         wr_strobe_r <= commit_r;
         for (int i = 0; i < NREG; i++) begin
            if (commit_r && (wr_idx_r == 6'(i))) begin
               reg_arr_r[i] <= rx_sh_r;
            end
         end
      end
   end

   // Memory address: restart on select, advance after each word load (wraps).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_addr_r <= {MEM_AW{1'b0}};
      end else if ((state_r == IDLE) && ncs_fall_s) begin
         mem_addr_r <= {MEM_AW{1'b0}};
      end else if (mem_inc_r) begin
         mem_addr_r <= mem_addr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
      end
   end

   genvar g;
   generate
      for (g = 0; g < NREG; g++) begin : g_reg_q
         assign reg_q[g*DW +: DW] = reg_arr_r[g];
      end
   endgenerate

   assign miso      = tx_sh_r[SW-1];
   assign wr_strobe = wr_strobe_r;
   assign wr_idx    = wr_idx_r;
   assign err       = err_r;
   assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_spi_regbank.sv
module tb_spi_regbank;

   localparam int NREG   = 4;
   localparam int DW     = 32;
   localparam int MEM_AW = 12;
   localparam int MEM_DW = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                sck = 1'b0;
   logic                mosi = 1'b0;
   logic                ncs = 1'b1;
   logic                miso;
   logic [NREG*DW-1:0]  reg_d;
   logic [NREG*DW-1:0]  reg_q;
   logic                wr_strobe;
   logic [5:0]          wr_idx;
   logic                err;
   logic [MEM_DW-1:0]   mem_data = 16'h0000;
   logic [MEM_AW-1:0]   mem_addr;

   int                  n_checks = 0;
   int                  n_fail = 0;
   int                  strobe_cnt = 0;
   logic [5:0]          last_idx = 6'd0;
   int                  s0;
   logic [63:0]         m;

   spi_regbank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sck       (sck),
      .mosi      (mosi),
      .ncs       (ncs),
      .miso      (miso),
      .reg_d     (reg_d),
      .reg_q     (reg_q),
      .wr_strobe (wr_strobe),
      .wr_idx    (wr_idx),
      .err       (err),
      .mem_data  (mem_data),
      .mem_addr  (mem_addr)
   );

   always #5 clk = ~clk;

   // Memory model: returns ~addr, one clk latency.
   always @(posedge clk) mem_data <= ~{4'h0, mem_addr};

   // Strobe monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (wr_strobe === 1'b1) begin
         strobe_cnt <= strobe_cnt + 1;
         last_idx   <= wr_idx;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic spi_bit(input logic b, output logic mo);
      sck  = 1'b0;
      mosi = b;
      repeat (8) @(posedge clk);
      #1 mo = miso;
      sck = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic spi_bits(input logic [63:0] v, input int n, output logic [63:0] mo);
      logic b;
      mo = 64'd0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_bit(v[i], b);
         mo = {mo[62:0], b};
      end
   endtask

   task automatic spi_start();
      ncs = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   // Select is released while sck is still high, then sck returns low.
   task automatic spi_end();
      ncs = 1'b1;
      repeat (4) @(posedge clk);
      #1 sck = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      reg_d = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      check("rst_reg_q", reg_q, 128'd0);
      check("rst_strobe", wr_strobe, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_mem_addr", mem_addr, 12'd0);
      check("rst_miso", miso, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Write reg 0, with first-bit latency check
      s0  = strobe_cnt;
      ncs = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("first_bit", miso, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      spi_bits(64'h80, 8, m);
      check("wr0_ctrl_miso", m[7:0], 8'hA5);
      spi_bits(64'h12345678, 32, m);
      check("wr0_data_miso", m[31:0], 32'h0);
      spi_end();
      check("wr0_reg_q0", reg_q[31:0], 32'h12345678);
      check("wr0_strobes", strobe_cnt - s0, 1);
      check("wr0_idx", last_idx, 6'd0);

      // Read-only reg 1: read status, write ignored
      spi_start();
      spi_bits(64'h01, 8, m);
      check("rd1_ctrl_miso", m[7:0], 8'hA5);
      spi_bits(64'h0, 32, m);
      check("rd1_data", m[31:0], 32'hDEADBEEF);
      spi_end();
      s0 = strobe_cnt;
      spi_start();
      spi_bits(64'h81, 8, m);
      spi_bits(64'h55555555, 32, m);
      spi_end();
      check("wr1_strobes", strobe_cnt - s0, 0);
      check("wr1_reg_q1", reg_q[63:32], 32'h0);
      check("wr1_err", err, 1'b0);

      // Read back writable reg 0
      spi_start();
      spi_bits(64'h00, 8, m);
      spi_bits(64'h0, 32, m);
      spi_end();
      check("rd0_data", m[31:0], 32'h12345678);

      // Memory stream of three words
      spi_start();
      spi_bits(64'h40, 8, m);
      check("mem_ctrl_miso", m[7:0], 8'hA5);
      spi_bits(64'h0, 16, m);
      check("mem_w0", m[15:0], 16'hFFFF);
      spi_bits(64'h0, 16, m);
      check("mem_w1", m[15:0], 16'hFFFE);
      spi_bits(64'h0, 16, m);
      check("mem_w2", m[15:0], 16'hFFFD);
      spi_end();
      check("mem_addr_end", mem_addr, 12'd3);

      // Partial write to reg 2 is discarded
      s0 = strobe_cnt;
      spi_start();
      spi_bits(64'h82, 8, m);
      spi_bits(64'hABC, 12, m);
      spi_end();
      check("part_reg_q2", reg_q[95:64], 32'h0);
      check("part_strobes", strobe_cnt - s0, 0);

      // Bad index sets err; signature changes; write to bad index ignored
      spi_start();
      spi_bits(64'h05, 8, m);
      check("bad_ctrl_miso", m[7:0], 8'hA5);
      spi_bits(64'h0, 32, m);
      check("bad_data_miso", m[31:0], 32'h0);
      spi_end();
      check("bad_err_set", err, 1'b1);
      s0 = strobe_cnt;
      spi_start();
      spi_bits(64'h85, 8, m);
      check("err_ctrl_miso", m[7:0], 8'h25);
      spi_bits(64'hFFFFFFFF, 32, m);
      spi_end();
      check("bad_wr_strobes", strobe_cnt - s0, 0);
      check("bad_wr_err", err, 1'b1);
      spi_start();
      spi_bits(64'hBF, 8, m);
      check("clr_ctrl_miso", m[7:0], 8'h25);
      spi_bits(64'h0000_0001, 32, m);
      spi_end();
      check("clr_err", err, 1'b0);
      check("clr_strobes", strobe_cnt - s0, 0);

      // Two words to reg 2: burst fills reg 3, otherwise second word drained
      s0 = strobe_cnt;
      spi_start();
      spi_bits(64'h82, 8, m);
      check("b_ctrl_miso", m[7:0], 8'hA5);
      spi_bits(64'hA1B2C3D4, 32, m);
      check("b_w0_miso", m[31:0], 32'h0);
      spi_bits(64'h5566778A, 32, m);
      check("b_w1_miso", m[31:0], 32'h0);
      spi_end();
      check("b_reg_q2", reg_q[95:64], 32'hA1B2C3D4);
`ifdef SPI_REGBANK_BURST_EN
      check("b_reg_q3", reg_q[127:96], 32'h5566778A);
      check("b_strobes", strobe_cnt - s0, 2);
      check("b_last_idx", last_idx, 6'd3);
`else
      check("b_reg_q3", reg_q[127:96], 32'h0);
      check("b_strobes", strobe_cnt - s0, 1);
      check("b_last_idx", last_idx, 6'd2);
`endif

      // Reset mid-word aborts the transaction
      s0 = strobe_cnt;
      spi_start();
      spi_bits(64'h83, 8, m);
      spi_bits(64'h3FF, 10, m);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_reg_q", reg_q, 128'd0);
      check("mid_rst_strobe", wr_strobe, 1'b0);
      check("mid_rst_idx", wr_idx, 6'd0);
      check("mid_rst_err", err, 1'b0);
      check("mid_rst_mem_addr", mem_addr, 12'd0);
      check("mid_rst_miso", miso, 1'b0);
      rst_n = 1'b1;
      spi_bits(64'h3FFFFF, 22, m);
      check("post_rst_miso", m[21:0], 22'h0);
      spi_end();
      check("post_rst_strobes", strobe_cnt - s0, 0);
      check("post_rst_reg_q3", reg_q[127:96], 32'h0);

      // Fresh transaction after reset works
      spi_start();
      spi_bits(64'h83, 8, m);
      check("fresh_ctrl_miso", m[7:0], 8'hA5);
      spi_bits(64'h0F0F0F0F, 32, m);
      spi_end();
      check("fresh_reg_q3", reg_q[127:96], 32'h0F0F0F0F);
      check("fresh_idx", last_idx, 6'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_regbank.md
SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 Parameter NREG, default 4: number of host-visible registers, 1..64.
REQ-002 Parameter DW, default 32: register width in bits, 8..64.
REQ-003 Parameter RO_MASK, default 4'b0010: bit i=1 makes register i read-only status; NREG bits wide.
REQ-004 Parameter RST_VAL, default 0: reset value of every writable register.
REQ-005 Parameters MEM_AW, default 12, and MEM_DW, default 16: memory address width and memory data width.
REQ-006 Ports: clk in 1 system clock; rst_n in 1 reset, synchronous, active-low.
REQ-007 Ports: sck in 1, mosi in 1, ncs in 1: raw asynchronous SPI inputs; miso out 1: SPI data out.
REQ-008 Ports: reg_d in NREG*DW status inputs, slice i for register i; reg_q out NREG*DW writable register contents.
REQ-009 Ports: wr_strobe out 1 write-commit pulse; wr_idx out 6 index of the committed register; err out 1 sticky bad-index flag.
REQ-010 Ports: mem_data in MEM_DW read data; mem_addr out MEM_AW read address.

Function
REQ-011 sck, mosi and ncs SHALL pass through 2-flop synchronisers; sck edges SHALL be detected from the synchronised signal, and clk SHALL be at least 8x sck.
REQ-012 SPI mode 0, MSB first: mosi sampled on the detected sck rise; miso updated on the detected sck fall; the first bit SHALL be driven within 3 clk of the detected ncs fall.
REQ-013 Transaction: ncs fall, then an 8-bit control byte {wr, mem, idx[5:0]}, then data words until ncs rises.
REQ-014 States: IDLE, CTRL, REG, MEM, DRAIN. ncs fall: IDLE->CTRL. 8th bit: CTRL->REG if mem=0, CTRL->MEM if mem=1. ncs rise from any state: ->IDLE.
REQ-015 During CTRL, miso SHALL shift out 8'hA5 when err=0 and 8'h25 when err=1.
REQ-016 REG read: on entry, the shift register SHALL load reg_d[i] when RO_MASK[i]=1, else reg_q[i]; DW bits are shifted out.
REQ-017 REG write (wr=1, RO_MASK[i]=0, i<NREG): on the DW-th sampled bit, reg_q[i] SHALL update one clk later; wr_strobe SHALL pulse high for 1 clk with wr_idx=i.
REQ-018 A write to a read-only register SHALL be ignored: no strobe, err unchanged.
REQ-019 idx>=NREG: miso SHALL output zeros, writes are ignored, and err SHALL set.
REQ-020 ncs rise before the DW-th bit SHALL discard the partial word: no reg_q change, no strobe.
REQ-021 MEM: mem_addr SHALL be 0 on entry to MEM. At each word start, mem_data SHALL load into the shift register and mem_addr SHALL increment one clk later. Memory read latency is 1 clk. mem_addr SHALL wrap from 2^MEM_AW-1 to 0.
REQ-022 After the first REG word without burst, the block SHALL enter DRAIN: miso=0, further bits ignored.
REQ-023 miso SHALL be 0 in IDLE.

Reset
REQ-024 When rst_n=0 at a clk edge: reg_q=RST_VAL except read-only slices, which SHALL be 0; wr_strobe=0, wr_idx=0, err=0, mem_addr=0, miso=0, state=IDLE.
REQ-025 Reset mid-transaction SHALL abort it; the block SHALL wait for a fresh ncs fall.
REQ-026 err SHALL clear only on reset or on a write of any value to a control byte with idx=6'h3F, wr=1, mem=0.

Configuration
REQ-027 Macro SPI_REGBANK_BURST_EN.
- Defined: after each REG word, idx SHALL auto-increment and the next word SHALL address idx+1. Each word SHALL follow the REQ-016 to REQ-019 rules independently. Past NREG-1 the REQ-019 rule SHALL apply.
- Undefined: REQ-022 behaviour.

Verification
REQ-028 Write 0x12345678 to reg 0 (ctrl 0x80) -> reg_q[0]=0x12345678, one wr_strobe with wr_idx=0, miso during CTRL=0xA5.
REQ-029 reg_d[1]=0xDEADBEEF, read reg 1 (ctrl 0x01) -> miso word 0xDEADBEEF; write to reg 1 (ctrl 0x81) -> no strobe.
REQ-030 MEM read (ctrl 0x40), 3 words, memory model returns ~addr -> miso 0xFFFF, 0xFFFE, 0xFFFD; mem_addr ends at 3.
REQ-031 Write reg 2 with ncs rising after 20 bits -> reg_q[2] unchanged, no strobe.
REQ-032 Ctrl 0x05 with NREG=4 -> miso zeros, err=1, next CTRL byte 0x25; ctrl 0xBF -> err=0.
REQ-033 BURST_EN defined: ctrl 0x82, two words A,B -> reg_q[2]=A, reg_q[3]=B, two strobes; rst_n low mid-word -> all outputs at reset values.
